glitcbus_master: RTL and testbench

- Initiator (TISC-side) end of GLITCBUS; mirror of the GLITC bus slave.
- Converts single-word local requests (16-bit address, 32-bit data, read/write) into byte-serial transactions on GSEL_B/GRDWR_B/GAD[7:0].
- Used in TISC firmware and as the bus driver in GLITC system benches.
- GCLK is forwarded from clk_i outside this block; GAD tristate buffer is instantiated at the top level.

---
 rtl/glitcbus_master_if.sv | 26 ++
 rtl/glitcbus_master.sv | 151 +++++++++++++++
 tb/tb_glitcbus_master.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glitcbus_master_if.sv
// GLITCBUS initiator interface: local request side plus the byte-serial bus side.
// The master modport is the initiator's view; the slave modport is the opposite end.
interface glitcbus_master_if;
  logic        req_i;
  logic        wr_i;
  logic [15:0] addr_i;
  logic [31:0] dat_i;
  logic        busy_o;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        GSEL_B_o;
  logic        GRDWR_B_o;
  logic [7:0]  gad_o;
  logic        gad_oe_o;
  logic [7:0]  gad_i;

  modport master (
    input  req_i, wr_i, addr_i, dat_i, gad_i,
    output busy_o, ack_o, dat_o, GSEL_B_o, GRDWR_B_o, gad_o, gad_oe_o
  );

  modport slave (
    output req_i, wr_i, addr_i, dat_i, gad_i,
    input  busy_o, ack_o, dat_o, GSEL_B_o, GRDWR_B_o, gad_o, gad_oe_o
  );
endinterface

// File: rtl/glitcbus_master.sv
// GLITCBUS initiator: turns one local 16-bit-address / 32-bit-data request into
// a byte-serial GSEL_B/GRDWR_B/GAD transaction. Bus outputs are decoded from the
// FSM state so GAD is only ever driven in the address and write-data phases.
module glitcbus_master #(
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  glitcbus_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    WDATA,
    TURN,
    RDATA,
    GAP
  } state_t;

  localparam logic [2:0] TURN_LAST = 3'(TURNAROUND - 1);
  localparam logic [2:0] GAP_LAST  = 3'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

  state_t      state;
  state_t      state_next;
  logic [2:0]  cnt;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [31:0] wdat_q;
  logic [23:0] shift_q;
  logic [31:0] rdat_q;
  logic        ack_q;

  logic        sel_b;
  logic        rdwr_b;
  logic [7:0]  gad;
  logic        oe;

  // State register; a low reset returns to IDLE and abandons any transaction.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and bus-output decode; GSEL_B and GRDWR_B only leave 1 while a transaction is on the bus.
  always_comb begin
    state_next = state;
    sel_b      = 1'b1;
    rdwr_b     = 1'b1;
    gad        = 8'h00;
    oe         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_i) begin
          state_next = ADDR_H;
        end
      end
      ADDR_H: begin
        sel_b      = 1'b0;
        rdwr_b     = ~wr_q;
        oe         = 1'b1;
        gad        = addr_q[15:8];
        state_next = ADDR_L;
      end
      ADDR_L: begin
        sel_b      = 1'b0;
        rdwr_b     = ~wr_q;
        oe         = 1'b1;
        gad        = addr_q[7:0];
        state_next = wr_q ? WDATA : TURN;
      end
      WDATA: begin
        sel_b  = 1'b0;
        rdwr_b = ~wr_q;
        oe     = 1'b1;
        case (cnt[1:0])
          2'd0:    gad = wdat_q[31:24];
          2'd1:    gad = wdat_q[23:16];
          2'd2:    gad = wdat_q[15:8];
          default: gad = wdat_q[7:0];
        endcase
        if (cnt == 3'd3) begin
          state_next = (IDLE_GAP == 0) ? IDLE : GAP;
        end
      end
      TURN: begin
        sel_b  = 1'b0;
        rdwr_b = ~wr_q;
        if (cnt == TURN_LAST) begin
          state_next = RDATA;
        end
      end
      RDATA: begin
        sel_b  = 1'b0;
        rdwr_b = ~wr_q;
        if (cnt == 3'd3) begin
          state_next = (IDLE_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, per-state cycle counter, read shifter, read result and completion pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt     <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdat_q  <= 32'h0000_0000;
      shift_q <= 24'h00_0000;
      rdat_q  <= 32'h0000_0000;
      ack_q   <= 1'b0;
    end else begin
      cnt   <= (state_next != state) ? 3'd0 : cnt + 3'd1;
      ack_q <= ((state == WDATA) || (state == RDATA)) && (cnt == 3'd3);
      if ((state == IDLE) && bus.req_i) begin
        wr_q   <= bus.wr_i;
        addr_q <= bus.addr_i;
        wdat_q <= bus.dat_i;
      end
      if (state == RDATA) begin
        shift_q <= {shift_q[15:0], bus.gad_i};
        if (cnt == 3'd3) begin
          rdat_q <= {shift_q, bus.gad_i};
        end
      end
    end
  end

  assign bus.busy_o    = (state != IDLE);
  assign bus.ack_o     = ack_q;
  assign bus.dat_o     = rdat_q;
  assign bus.GSEL_B_o  = sel_b;
  assign bus.GRDWR_B_o = rdwr_b;
  assign bus.gad_o     = gad;
  assign bus.gad_oe_o  = oe;

endmodule

// File: tb/tb_glitcbus_master.sv
// Bench for glitcbus_master: three instances (TURNAROUND/IDLE_GAP = 2/1, 4/1, 2/0)
// share one stimulus stream. Stimulus pushes expected transactions into a
// per-instance queue; a monitor captures the bus and pops/compares on ack_o.
module tb_glitcbus_master;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic [31:0] dat_exp;
    int          low_len;
    int          ack_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] dat;
  logic [31:0] rd_word;

  logic        gsel    [3];
  logic        grdwr   [3];
  logic        oe      [3];
  logic        busy    [3];
  logic        ack     [3];
  logic [7:0]  gad_out [3];
  logic [7:0]  gad_in  [3];
  logic [31:0] dato    [3];

  exp_t        exp_q   [3][$];
  logic [31:0] last_rd [3];
  logic [7:0]  cap_b   [3][16];
  logic        cap_oe  [3][16];
  logic        cap_rw  [3][16];
  int          pos     [3];
  int          busy_run[3];

  int   cyc;
  logic rst_seen;
  logic done;
  logic done_chk;
  int   checks;
  int   failures;

  for (genvar g = 0; g < 3; g++) begin : inst
    glitcbus_master_if ifc ();
    assign ifc.req_i  = req;
    assign ifc.wr_i   = wr;
    assign ifc.addr_i = addr;
    assign ifc.dat_i  = dat;
    assign ifc.gad_i  = gad_in[g];
    assign gsel[g]    = ifc.GSEL_B_o;
    assign grdwr[g]   = ifc.GRDWR_B_o;
    assign oe[g]      = ifc.gad_oe_o;
    assign busy[g]    = ifc.busy_o;
    assign ack[g]     = ifc.ack_o;
    assign gad_out[g] = ifc.gad_o;
    assign dato[g]    = ifc.dat_o;
    glitcbus_master #(
      .TURNAROUND((g == 1) ? 4 : 2),
      .IDLE_GAP  ((g == 2) ? 0 : 1)
    ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (ifc.master)
    );
  end

  function automatic int tg(input int g);
    return (g == 1) ? 4 : 2;
  endfunction

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter and a record of whether this edge saw reset asserted.
  always @(posedge clk) begin
    cyc      = cyc + 1;
    rst_seen = ~rst_n;
  end

  // Absolute time limit in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task check_output(input string name, input int g, input logic [31:0] act, input logic [31:0] req_v);
    checks = checks + 1;
    if (act !== req_v) begin
      failures = failures + 1;
      $display("[TB] FAIL %s inst=%0d actual=%h required=%h", name, g, act, req_v);
    end
  endtask

  // Monitor and slave model: captures bus bytes, drives read data, pops and compares on ack.
  always @(negedge clk) begin
    exp_t        e;
    int          n;
    int          bad;
    int          k;
    logic        oe_e;
    logic        rw_e;
    logic [7:0]  b_e;
    for (int g = 0; g < 3; g++) begin
      if (rst_seen) begin
        checks = checks + 1;
        if (gsel[g] !== 1'b1 || grdwr[g] !== 1'b1 || gad_out[g] !== 8'h00 || oe[g] !== 1'b0 ||
            busy[g] !== 1'b0 || ack[g] !== 1'b0 || dato[g] !== 32'h0) begin
          failures = failures + 1;
          $display("[TB] FAIL reset_state inst=%0d actual sel=%b rw=%b gad=%h oe=%b busy=%b ack=%b dat=%h required sel=1 rw=1 gad=00 oe=0 busy=0 ack=0 dat=00000000",
                   g, gsel[g], grdwr[g], gad_out[g], oe[g], busy[g], ack[g], dato[g]);
        end
        exp_q[g].delete();
        pos[g]      = 0;
        busy_run[g] = 0;
        gad_in[g]   = 8'h5A;
      end else begin
        if (gsel[g] === 1'b0) begin
          if (pos[g] < 16) begin
            cap_b[g][pos[g]]  = gad_out[g];
            cap_oe[g][pos[g]] = oe[g];
            cap_rw[g][pos[g]] = grdwr[g];
          end
          k = pos[g] - 2 - tg(g);
          if (grdwr[g] === 1'b1 && k >= 0 && k < 4) begin
            gad_in[g] = 8'(rd_word >> (24 - 8 * k));
          end else begin
            gad_in[g] = 8'hC0 + 8'(pos[g]);
          end
          pos[g] = pos[g] + 1;
        end else begin
          gad_in[g] = 8'h5A;
        end
        if (ack[g] === 1'b1) begin
          if (exp_q[g].size() == 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL unexpected_ack inst=%0d actual ack=1 required no ack at cycle %0d", g, cyc);
          end else begin
            e = exp_q[g].pop_front();
            check_output("ack_cycle", g, 32'(cyc), 32'(e.ack_cyc));
            check_output("gsel_low_cycles", g, 32'(pos[g]), 32'(e.low_len));
            check_output("dat_o", g, dato[g], e.dat_exp);
            n   = (pos[g] < e.low_len) ? pos[g] : e.low_len;
            n   = (n > 16) ? 16 : n;
            bad = -1;
            for (int i = 0; i < n; i++) begin
              oe_e = e.wr || (i < 2);
              rw_e = ~e.wr;
              if (i == 0)      b_e = e.addr[15:8];
              else if (i == 1) b_e = e.addr[7:0];
              else             b_e = 8'(e.wdat >> (8 * (5 - i)));
              if (bad < 0 && (cap_oe[g][i] !== oe_e || cap_rw[g][i] !== rw_e ||
                              (oe_e && cap_b[g][i] !== b_e))) begin
                bad = i;
              end
            end
            checks = checks + 1;
            if (bad >= 0) begin
              failures = failures + 1;
              $display("[TB] FAIL bus_bytes inst=%0d slot=%0d actual oe=%b rw=%b gad=%h required oe=%b rw=%b gad=%h",
                       g, bad, cap_oe[g][bad], cap_rw[g][bad], cap_b[g][bad],
                       e.wr || (bad < 2), ~e.wr,
                       (bad == 0) ? e.addr[15:8] : (bad == 1) ? e.addr[7:0] : 8'(e.wdat >> (8 * (5 - bad))));
            end
          end
          pos[g] = 0;
        end
        if (busy[g] === 1'b1) begin
          busy_run[g] = busy_run[g] + 1;
        end else begin
          busy_run[g] = 0;
        end
        if (busy_run[g] == 40) begin
          checks   = checks + 1;
          failures = failures + 1;
          $display("[TB] FAIL busy_timeout inst=%0d actual busy=1 for 40 cycles required ack and idle", g);
        end
      end
    end
    if (done && !done_chk) begin
      done_chk = 1'b1;
      for (int g = 0; g < 3; g++) begin
        check_output("pending_at_end", g, 32'(exp_q[g].size()), 32'd0);
      end
    end
  end

  task wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1] && !busy[2]) break;
    end
    @(negedge clk);
  endtask

  task push_expect(input logic w, input logic [15:0] a, input logic [31:0] d, input int g, input int acc);
    exp_t e;
    e.wr      = w;
    e.addr    = a;
    e.wdat    = d;
    e.low_len = w ? 6 : 6 + tg(g);
    e.ack_cyc = acc + e.low_len;
    if (!w) last_rd[g] = rd_word;
    e.dat_exp = last_rd[g];
    exp_q[g].push_back(e);
  endtask

  task apply_stimulus(input logic w, input logic [15:0] a, input logic [31:0] d);
    int acc;
    @(negedge clk);
    req  = 1'b1;
    wr   = w;
    addr = a;
    dat  = d;
    acc  = cyc + 1;
    for (int g = 0; g < 3; g++) push_expect(w, a, d, g, acc);
    @(negedge clk);
    req = 1'b0;
    wait_idle();
  endtask

  // Two writes with req held high: requests during busy are dropped, the next is taken in IDLE.
  task back_to_back();
    int acc;
    @(negedge clk);
    req  = 1'b1;
    wr   = 1'b1;
    addr = 16'h4455;
    dat  = 32'h0123_4567;
    acc  = cyc + 1;
    for (int g = 0; g < 3; g++) begin
      push_expect(1'b1, 16'h4455, 32'h0123_4567, g, acc);
      push_expect(1'b1, 16'h66AA, 32'h89AB_CDEF, g, (g == 2) ? acc + 7 : acc + 8);
    end
    @(negedge clk);
    addr = 16'h66AA;
    dat  = 32'h89AB_CDEF;
    while (cyc < acc + 8) @(negedge clk);
    req = 1'b0;
    wait_idle();
  endtask

  // Read abandoned by reset during the second read-data byte of the TURNAROUND=2 instances.
  task reset_mid_read();
    int acc;
    rd_word = 32'hFFFF_0000;
    @(negedge clk);
    req  = 1'b1;
    wr   = 1'b0;
    addr = 16'h0F0F;
    acc  = cyc + 1;
    @(negedge clk);
    req = 1'b0;
    while (cyc < acc + 5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) last_rd[g] = 32'h0;
    repeat (3) @(negedge clk);
  endtask

  // Directed sequence.
  initial begin
    cyc      = 0;
    rst_seen = 1'b0;
    done     = 1'b0;
    done_chk = 1'b0;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 1'b0;
    wr       = 1'b0;
    addr     = 16'h0;
    dat      = 32'h0;
    rd_word  = 32'h0;
    for (int g = 0; g < 3; g++) begin
      last_rd[g]  = 32'h0;
      pos[g]      = 0;
      busy_run[g] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(1'b1, 16'h0023, 32'hDEAD_BEEF);
    rd_word = 32'h1234_5678;
    apply_stimulus(1'b0, 16'h0812, 32'h0);
    back_to_back();
    rd_word = 32'h9ABC_DEF0;
    apply_stimulus(1'b0, 16'hFFFF, 32'h0);
    reset_mid_read();
    apply_stimulus(1'b1, 16'h00A5, 32'h0102_0304);
    rd_word = 32'hCAFE_F00D;
    apply_stimulus(1'b0, 16'h0000, 32'h0);

    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
